// File: rtl/vc_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vc_buffer
// Description : Multi-virtual-channel router input buffer. NUM_VC independent
//               FIFOs of DEPTH packets share one write port and one
//               first-word-fall-through read port. Provides per-VC occupancy,
//               full/empty/almost-full flags, and overflow/underflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_buffer #(
  parameter  int PAC_WIDTH = 64,
  parameter  int DEPTH     = 4,
  parameter  int NUM_VC    = 2,
  localparam int VC_W      = $clog2(NUM_VC),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wen,
  input  logic [VC_W-1:0]           wvc,
  input  logic [PAC_WIDTH-1:0]      d_in,
  input  logic                      ren,
  input  logic [VC_W-1:0]           rvc,
  output logic [PAC_WIDTH-1:0]      d_out,
  output logic [NUM_VC-1:0]         full,
  output logic [NUM_VC-1:0]         empty,
  output logic [NUM_VC-1:0]         almost_full,
  output logic [NUM_VC*CNT_W-1:0]   count,
  output logic                      wr_err,
  output logic                      rd_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PAC_WIDTH-1:0] r_mem  [NUM_VC][DEPTH];
  logic [PTR_W-1:0]     r_wptr [NUM_VC];
  logic [PTR_W-1:0]     r_rptr [NUM_VC];
  logic [CNT_W-1:0]     r_cnt  [NUM_VC];
  logic                 r_wr_err;
  logic                 r_rd_err;

  logic [NUM_VC-1:0]    w_full;
  logic [NUM_VC-1:0]    w_empty;
  logic [NUM_VC-1:0]    w_af;
  logic [NUM_VC-1:0]    w_wr_hit;
  logic [NUM_VC-1:0]    w_rd_hit;
  logic                 w_renq;
  logic                 w_wenq;

  // Per-VC flag decode from the registered counts, plus per-VC hit strobes
  generate
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      assign w_full[v]   = (r_cnt[v] == CNT_W'(DEPTH));
      assign w_empty[v]  = (r_cnt[v] == '0);
      assign w_af[v]     = (r_cnt[v] >= CNT_W'(DEPTH - 1));
      assign w_wr_hit[v] = w_wenq & (wvc == VC_W'(v));
      assign w_rd_hit[v] = w_renq & (rvc == VC_W'(v));
      assign count[v*CNT_W +: CNT_W] = r_cnt[v];
    end
  endgenerate

  // Request qualification: a write to a full VC is allowed only when the
  // same edge also pops that VC, freeing the slot being written.
  always_comb begin
    w_renq = ren & ~w_empty[rvc];
    w_wenq = wen & (~w_full[wvc] | (w_renq & (wvc == rvc)));
  end

  // First-word fall-through: head of the selected VC, stale when empty
  assign d_out       = r_mem[rvc][r_rptr[rvc]];
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = w_af;
  assign wr_err      = r_wr_err;
  assign rd_err      = r_rd_err;

  // Storage, pointers, occupancy and error pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        for (int e = 0; e < DEPTH; e++) begin
          r_mem[v][e] <= '0;
        end
        r_wptr[v] <= '0;
        r_rptr[v] <= '0;
        r_cnt[v]  <= '0;
      end
      r_wr_err <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_wr_hit[v]) begin
          r_mem[v][r_wptr[v]] <= d_in;
          r_wptr[v]           <= r_wptr[v] + PTR_W'(1);
        end
        if (w_rd_hit[v]) begin
          r_rptr[v] <= r_rptr[v] + PTR_W'(1);
        end
        // Simultaneous push and pop on one VC leaves its occupancy unchanged
        if (w_wr_hit[v] && !w_rd_hit[v]) begin
          r_cnt[v] <= r_cnt[v] + CNT_W'(1);
        end else if (!w_wr_hit[v] && w_rd_hit[v]) begin
          r_cnt[v] <= r_cnt[v] - CNT_W'(1);
        end
      end
      r_wr_err <= wen & ~w_wenq;
      r_rd_err <= ren & ~w_renq;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vc_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_buffer
// Description : Directed, table-driven self-checking bench for vc_buffer
//               (PAC_WIDTH=64, DEPTH=4, NUM_VC=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_buffer;

  logic        clk;
  logic        reset;
  logic        wen;
  logic        wvc;
  logic [63:0] d_in;
  logic        ren;
  logic        rvc;
  logic [63:0] d_out;
  logic [1:0]  full;
  logic [1:0]  empty;
  logic [1:0]  almost_full;
  logic [5:0]  count;
  logic        wr_err;
  logic        rd_err;

  vc_buffer #(.PAC_WIDTH(64), .DEPTH(4), .NUM_VC(2)) dut (
    .clk(clk), .reset(reset), .wen(wen), .wvc(wvc), .d_in(d_in),
    .ren(ren), .rvc(rvc), .d_out(d_out), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .wr_err(wr_err), .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs held for one cycle; expectations describe the state
  // seen before that cycle's rising edge (errors from the previous edge).
  typedef struct {
    logic        wen;
    logic        wvc;
    logic [63:0] din;
    logic        ren;
    logic        rvc;
    logic        dchk;
    logic [63:0] edout;
    logic [2:0]  ec0;
    logic [2:0]  ec1;
    logic [1:0]  eempty;
    logic [1:0]  efull;
    logic [1:0]  eaf;
    logic        ewe;
    logic        ere;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add(input logic w, input logic wv, input logic [63:0] di,
                     input logic r, input logic rv, input logic dc,
                     input logic [63:0] ed, input logic [2:0] c0,
                     input logic [2:0] c1, input logic [1:0] ee,
                     input logic [1:0] ef, input logic [1:0] ea,
                     input logic we, input logic re);
    vec_t t;
    t.wen = w; t.wvc = wv; t.din = di; t.ren = r; t.rvc = rv;
    t.dchk = dc; t.edout = ed; t.ec0 = c0; t.ec1 = c1;
    t.eempty = ee; t.efull = ef; t.eaf = ea; t.ewe = we; t.ere = re;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
  endtask

  initial begin
    reset = 1'b0; wen = 1'b0; wvc = 1'b0; d_in = '0; ren = 1'b0; rvc = 1'b0;

    //   wen wvc din    ren rvc dchk dout   c0 c1 empty  full   af     we re
    add(0,0,64'h0,  0,0, 1,64'h0,  0,0,2'b11,2'b00,2'b00,0,0); // 0 reset state
    add(1,0,64'h1,  0,0, 0,64'h0,  0,0,2'b11,2'b00,2'b00,0,0); // 1 fill VC0
    add(1,0,64'h2,  0,0, 1,64'h1,  1,0,2'b10,2'b00,2'b00,0,0);
    add(1,0,64'h3,  0,0, 1,64'h1,  2,0,2'b10,2'b00,2'b00,0,0);
    add(1,0,64'h4,  0,0, 1,64'h1,  3,0,2'b10,2'b00,2'b01,0,0);
    add(0,0,64'h0,  0,0, 1,64'h1,  4,0,2'b10,2'b01,2'b01,0,0); // 5 full
    add(1,0,64'hFF, 0,0, 1,64'h1,  4,0,2'b10,2'b01,2'b01,0,0); // 6 overflow
    add(0,0,64'h0,  0,0, 1,64'h1,  4,0,2'b10,2'b01,2'b01,1,0); // 7 wr_err
    add(0,0,64'h0,  0,0, 1,64'h1,  4,0,2'b10,2'b01,2'b01,0,0); // 8 one cycle only
    add(1,0,64'h9,  1,0, 1,64'h1,  4,0,2'b10,2'b01,2'b01,0,0); // 9 full pass-through
    add(0,0,64'h0,  1,0, 1,64'h2,  4,0,2'b10,2'b01,2'b01,0,0);
    add(0,0,64'h0,  1,0, 1,64'h3,  3,0,2'b10,2'b00,2'b01,0,0);
    add(0,0,64'h0,  1,0, 1,64'h4,  2,0,2'b10,2'b00,2'b00,0,0);
    add(0,0,64'h0,  1,0, 1,64'h9,  1,0,2'b10,2'b00,2'b00,0,0);
    add(0,0,64'h0,  0,0, 0,64'h0,  0,0,2'b11,2'b00,2'b00,0,0); // 14 drained
    add(1,0,64'h1,  0,0, 0,64'h0,  0,0,2'b11,2'b00,2'b00,0,0); // 15 order/wrap
    add(1,0,64'h2,  0,0, 1,64'h1,  1,0,2'b10,2'b00,2'b00,0,0);
    add(1,0,64'h3,  0,0, 1,64'h1,  2,0,2'b10,2'b00,2'b00,0,0);
    add(1,0,64'h4,  0,0, 1,64'h1,  3,0,2'b10,2'b00,2'b01,0,0);
    add(0,0,64'h0,  1,0, 1,64'h1,  4,0,2'b10,2'b01,2'b01,0,0);
    add(0,0,64'h0,  1,0, 1,64'h2,  3,0,2'b10,2'b00,2'b01,0,0);
    add(1,0,64'h5,  0,0, 1,64'h3,  2,0,2'b10,2'b00,2'b00,0,0);
    add(1,0,64'h6,  0,0, 1,64'h3,  3,0,2'b10,2'b00,2'b01,0,0);
    add(0,0,64'h0,  1,0, 1,64'h3,  4,0,2'b10,2'b01,2'b01,0,0);
    add(0,0,64'h0,  1,0, 1,64'h4,  3,0,2'b10,2'b00,2'b01,0,0);
    add(0,0,64'h0,  1,0, 1,64'h5,  2,0,2'b10,2'b00,2'b00,0,0);
    add(0,0,64'h0,  1,0, 1,64'h6,  1,0,2'b10,2'b00,2'b00,0,0);
    add(0,0,64'h0,  0,0, 0,64'h0,  0,0,2'b11,2'b00,2'b00,0,0); // 27
    add(0,0,64'h0,  1,1, 0,64'h0,  0,0,2'b11,2'b00,2'b00,0,0); // 28 underflow
    add(0,0,64'h0,  0,1, 0,64'h0,  0,0,2'b11,2'b00,2'b00,0,1); // 29 rd_err
    add(1,1,64'h33, 1,1, 0,64'h0,  0,0,2'b11,2'b00,2'b00,0,0); // 30 same VC empty
    add(0,0,64'h0,  0,1, 1,64'h33, 0,1,2'b01,2'b00,2'b00,0,1); // 31 write taken
    add(0,0,64'h0,  1,1, 1,64'h33, 0,1,2'b01,2'b00,2'b00,0,0);
    add(0,0,64'h0,  0,1, 0,64'h0,  0,0,2'b11,2'b00,2'b00,0,0); // 33
    add(1,1,64'h20, 0,1, 0,64'h0,  0,0,2'b11,2'b00,2'b00,0,0); // 34 VC indep.
    add(1,1,64'h21, 1,1, 1,64'h20, 0,1,2'b01,2'b00,2'b00,0,0);
    add(1,0,64'h10, 1,1, 1,64'h21, 0,1,2'b01,2'b00,2'b00,0,0);
    add(1,1,64'h22, 0,1, 0,64'h0,  1,0,2'b10,2'b00,2'b00,0,0);
    add(1,0,64'h11, 1,1, 1,64'h22, 1,1,2'b00,2'b00,2'b00,0,0);
    add(0,0,64'h0,  0,0, 1,64'h10, 2,0,2'b10,2'b00,2'b00,0,0); // 39
    add(0,0,64'h0,  1,0, 1,64'h10, 2,0,2'b10,2'b00,2'b00,0,0);
    add(0,0,64'h0,  1,0, 1,64'h11, 1,0,2'b10,2'b00,2'b00,0,0);
    add(0,0,64'h0,  0,0, 0,64'h0,  0,0,2'b11,2'b00,2'b00,0,0); // 42

    // Release reset away from a rising edge
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      wen = vq[i].wen; wvc = vq[i].wvc; d_in = vq[i].din;
      ren = vq[i].ren; rvc = vq[i].rvc;
      #1;
      if (vq[i].dchk) chk("d_out", i, d_out, vq[i].edout);
      chk("count0", i, 64'(count[2:0]), 64'(vq[i].ec0));
      chk("count1", i, 64'(count[5:3]), 64'(vq[i].ec1));
      chk("empty", i, 64'(empty), 64'(vq[i].eempty));
      chk("full", i, 64'(full), 64'(vq[i].efull));
      chk("almost_full", i, 64'(almost_full), 64'(vq[i].eaf));
      chk("wr_err", i, 64'(wr_err), 64'(vq[i].ewe));
      chk("rd_err", i, 64'(rd_err), 64'(vq[i].ere));
    end

    // Mid-stream asynchronous reset with VC0 holding two packets
    @(negedge clk); wen = 1'b1; wvc = 1'b0; d_in = 64'h7; ren = 1'b0; rvc = 1'b0;
    @(negedge clk); d_in = 64'h8;
    @(negedge clk); d_in = 64'hEE;
    #1;
    chk("pre_rst_count0", 100, 64'(count[2:0]), 64'd2);
    chk("pre_rst_dout", 100, d_out, 64'h7);
    #1 reset = 1'b0;
    #1;
    chk("rst_empty", 101, 64'(empty), 64'(2'b11));
    chk("rst_count", 101, 64'(count), 64'd0);
    chk("rst_dout", 101, d_out, 64'h0);
    chk("rst_full", 101, 64'(full), 64'd0);
    chk("rst_af", 101, 64'(almost_full), 64'd0);
    @(posedge clk); #1;
    chk("rst_hold_count", 102, 64'(count), 64'd0);
    chk("rst_hold_errs", 102, 64'({wr_err, rd_err}), 64'd0);
    @(negedge clk); reset = 1'b1; wen = 1'b0;
    @(negedge clk); wen = 1'b1; wvc = 1'b1; d_in = 64'hA5;
    @(negedge clk); wen = 1'b0; rvc = 1'b1;
    #1;
    chk("post_rst_dout", 103, d_out, 64'hA5);
    chk("post_rst_count1", 103, 64'(count[5:3]), 64'd1);
    chk("post_rst_count0", 103, 64'(count[2:0]), 64'd0);
    chk("post_rst_empty", 103, 64'(empty), 64'(2'b01));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vc_buffer.md
Name: vc_buffer

Overview:
- Multi-virtual-channel input buffer for a router port: NUM_VC independent FIFOs, each DEPTH packets deep, sharing one write port and one read port.
- Successor to the single-entry packet buffer. Adds:
  - parametrised depth and channel count
  - per-VC occupancy and almost-full flags for credit/flow control
  - simultaneous read/write on a full VC
  - overflow/underflow error pulses
- Sits between the link input and the router crossbar/VC allocator.

Parameters:
PAC_WIDTH  64  packet width in bits
DEPTH  4  entries per VC; power of two, >= 2
NUM_VC  2  number of virtual channels; >= 2
VC_W  $clog2(NUM_VC)  VC index width (localparam, derived)
CNT_W  $clog2(DEPTH+1)  occupancy count width (localparam, derived)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
wen  input  1  write request
wvc  input  VC_W  target VC for write
d_in  input  PAC_WIDTH  write packet
ren  input  1  read request
rvc  input  VC_W  source VC for read; also selects d_out
d_out  output  PAC_WIDTH  head packet of VC rvc (combinational, first-word fall-through)
full  output  NUM_VC  bit v = VC v holds DEPTH packets
empty  output  NUM_VC  bit v = VC v holds 0 packets
almost_full  output  NUM_VC  bit v = count of VC v >= DEPTH-1
count  output  NUM_VC*CNT_W  per-VC occupancy; VC v in bits [v*CNT_W +: CNT_W]
wr_err  output  1  registered pulse: previous cycle's write was rejected
rd_err  output  1  registered pulse: previous cycle's read was rejected

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - all read pointers, write pointers and counts go to 0, and all storage clears to 0
  - outputs: empty = all ones; full = 0; almost_full = 0; count = 0; wr_err = 0; rd_err = 0; d_out = 0
  - reset asserted mid-operation discards all stored packets immediately; no partial write completes
  - normal operation resumes on the first rising edge after reset deasserts
- Qualification:
  - renq = ren & ~empty[rvc]
  - wenq = wen & (~full[wvc] | (renq & (wvc == rvc)))
- Write: on a clock edge with wenq, d_in is stored at the write pointer of wvc, and that write pointer advances by 1 modulo DEPTH.
- Read:
  - d_out always equals the entry at the read pointer of rvc, with zero latency.
  - On a clock edge with renq, that read pointer advances by 1 modulo DEPTH, and the packet is consumed.
  - When VC rvc is empty, d_out shows stale storage and is not valid.
- Count update, per VC:
  - +1 on write only
  - -1 on read only
  - unchanged when both hit the same VC or neither does
  - count never exceeds DEPTH and never goes below 0
- Flags: full, empty and almost_full are decoded combinationally from the registered counts, so they reflect the new state in the cycle after the edge.
- Simultaneous events:
  - Read and write to different VCs: both proceed independently.
  - Same VC, full: both are accepted; count stays DEPTH; the head is consumed and the new packet is appended.
  - Same VC, empty: the read is rejected; the write is accepted; the count becomes 1.
  - Same VC, partially filled: both are accepted; the count is unchanged.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. FIFO order is preserved across the wrap.
- Errors:
  - wr_err <= wen & ~wenq
  - rd_err <= ren & ~renq
  - Each is registered and high for exactly one cycle per rejected request.
  - A rejected request leaves storage, pointers and counts unchanged.
- Throughput: one write and one read per cycle, sustained.

Test Plan:
- Reset: drive reset=0 mid-stream with VC0 holding 2 packets -> immediately empty=2'b11, count=0, d_out=0; after release, a write of 0xA5 to VC1 followed by rvc=1 -> d_out=0xA5, count VC1=1.
- Fill/order/wrap, DEPTH=4:
  - write 0x1,0x2,0x3,0x4 to VC0 -> full[0]=1, almost_full[0]=1 from count 3
  - then read 2, write 0x5,0x6, read 4 -> outputs 0x1..0x6 in order, empty[0]=1
- Overflow: VC0 full, wen=1, ren=0, wvc=0, d_in=0xFF -> next cycle wr_err=1 for one cycle; count stays 4; the 0xFF packet is never read out.
- Underflow: VC1 empty, ren=1, rvc=1 -> next cycle rd_err=1; count stays 0. Same VC empty with wen=1 on the same edge -> write accepted, count=1, rd_err=1.
- Full pass-through: VC0 full with 0x1..0x4, wen=ren=1, wvc=rvc=0, d_in=0x9 -> 0x1 consumed, count stays 4, no wr_err; subsequent reads give 0x2,0x3,0x4,0x9.
- VC independence: interleave writes to VC0 (0x10..) and VC1 (0x20..) while reading VC1 every cycle -> VC1 data in order, VC0 count unaffected by VC1 reads, no cross-VC corruption.
